// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the colour-claiming turn game.
//   NUM_COLORS / NO_COLOR : colour count and the "no selection" code
//   color_t               : 4-bit colour code
//   turn_state_t          : turn sequencer states
//   color_onehot()        : colour code to claimed-mask bit (all zero for >= 12)
package game_pkg;

  localparam int         NUM_COLORS = 12;
  localparam logic [3:0] NO_COLOR   = 4'd12;
  localparam logic [NUM_COLORS-1:0] ALL_COLORS = 12'hFFF;

  typedef logic [3:0] color_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TURN_WAIT = 3'd1,
    CHECK     = 3'd2,
    COMMIT    = 3'd3,
    NEXT      = 3'd4,
    DONE      = 3'd5
  } turn_state_t;

  // Decoding through a compare loop keeps codes 12..15 from indexing past the mask.
  function automatic logic [NUM_COLORS-1:0] color_onehot(input color_t c);
    logic [NUM_COLORS-1:0] oh;
    oh = {NUM_COLORS{1'b0}};
    for (int i = 0; i < NUM_COLORS; i++) begin
      oh[i] = (c == 4'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to the countdown tick.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : forces the count back to 0 (turn entry)
//   en         : count enable; the count freezes while low
//   tick       : one-cycle pulse in the cycle whose edge wraps the count
module tick_prescaler
  import game_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Next count: clear wins, otherwise count 0..TICK_DIV-1 while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: two-player colour-claiming turn sequencer.
//   start         : pulse, starts/restarts a game from IDLE or DONE
//   color_id      : selector colour (0..11 valid, 12 = none)
//   confirm       : pulse, request to claim color_id (TURN_WAIT only)
//   active_player : player on turn
//   busy          : game in progress (TURN_WAIT/CHECK/COMMIT/NEXT)
//   time_left     : ticks left in the current turn
//   used_mask     : claimed colours
//   commit_valid/commit_player/commit_color : accepted move (pulse + held data)
//   reject        : pulse, invalid or already-claimed pick
//   timeout       : pulse, turn expired
//   game_over     : game finished (DONE)
// All outputs come straight from flops.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int TURN_TICKS = 30,
  parameter int MAX_TURNS  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  color_id,
  input  logic        confirm,
  output logic        active_player,
  output logic        busy,
  output logic [5:0]  time_left,
  output logic [11:0] used_mask,
  output logic        commit_valid,
  output logic        commit_player,
  output logic [3:0]  commit_color,
  output logic        reject,
  output logic        timeout,
  output logic        game_over
);

  localparam logic [5:0] TURN_TICKS_V = 6'(TURN_TICKS);
  localparam logic [3:0] MAX_TURNS_V  = 4'(MAX_TURNS);

  turn_state_t state_q, state_d;
  logic        active_q, active_d;
  logic [5:0]  time_left_q, time_left_d;
  logic [11:0] used_mask_q, used_mask_d;
  logic        commit_valid_q, commit_valid_d;
  logic        commit_player_q, commit_player_d;
  color_t      commit_color_q, commit_color_d;
  logic        reject_q, reject_d;
  logic        timeout_q, timeout_d;
  logic        busy_q, busy_d;
  logic        game_over_q, game_over_d;
  logic [3:0]  turn_cnt_q, turn_cnt_d;
  color_t      latched_q, latched_d;

  logic        tick_s;
  logic        en_s;
  logic        clr_s;
  logic [11:0] pick_oh_s;

  assign en_s      = (state_q == TURN_WAIT);
  assign pick_oh_s = color_onehot(latched_q);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .en    (en_s),
    .tick  (tick_s)
  );

  // Next-state and next-output logic for the turn sequencer.
  always_comb begin
    state_d         = state_q;
    active_d        = active_q;
    time_left_d     = time_left_q;
    used_mask_d     = used_mask_q;
    commit_valid_d  = 1'b0;
    commit_player_d = commit_player_q;
    commit_color_d  = commit_color_q;
    reject_d        = 1'b0;
    timeout_d       = 1'b0;
    turn_cnt_d      = turn_cnt_q;
    latched_d       = latched_q;
    clr_s           = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          used_mask_d = 12'h000;
          turn_cnt_d  = 4'd0;
          active_d    = 1'b0;
          time_left_d = TURN_TICKS_V;
          clr_s       = 1'b1;
          state_d     = TURN_WAIT;
        end else begin
          state_d = state_q;
        end
      end

      TURN_WAIT: begin
        // A non-final tick always counts; the final tick loses to a same-cycle confirm.
        if (tick_s) begin
          if (time_left_q > 6'd1) begin
            time_left_d = time_left_q - 6'd1;
          end else if (!confirm) begin
            time_left_d = 6'd0;
            timeout_d   = 1'b1;
            state_d     = NEXT;
          end else begin
            time_left_d = time_left_q;
          end
        end else begin
          time_left_d = time_left_q;
        end
        if (confirm) begin
          latched_d = color_id;
          state_d   = CHECK;
        end else begin
          latched_d = latched_q;
        end
      end

      CHECK: begin
        if ((latched_q >= NO_COLOR) || ((used_mask_q & pick_oh_s) != 12'h000)) begin
          reject_d = 1'b1;
          state_d  = TURN_WAIT;
        end else begin
          commit_valid_d  = 1'b1;
          commit_player_d = active_q;
          commit_color_d  = latched_q;
          used_mask_d     = used_mask_q | pick_oh_s;
          turn_cnt_d      = turn_cnt_q + 4'd1;
          state_d         = COMMIT;
        end
      end

      COMMIT: begin
        state_d = NEXT;
      end

      NEXT: begin
        active_d = ~active_q;
        if ((turn_cnt_q == MAX_TURNS_V) || (used_mask_q == ALL_COLORS)) begin
          state_d = DONE;
        end else begin
          time_left_d = TURN_TICKS_V;
          clr_s       = 1'b1;
          state_d     = TURN_WAIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d == TURN_WAIT) || (state_d == CHECK) ||
                  (state_d == COMMIT)    || (state_d == NEXT);
    game_over_d = (state_d == DONE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      active_q        <= 1'b0;
      time_left_q     <= 6'd0;
      used_mask_q     <= 12'h000;
      commit_valid_q  <= 1'b0;
      commit_player_q <= 1'b0;
      commit_color_q  <= NO_COLOR;
      reject_q        <= 1'b0;
      timeout_q       <= 1'b0;
      busy_q          <= 1'b0;
      game_over_q     <= 1'b0;
      turn_cnt_q      <= 4'd0;
      latched_q       <= 4'd0;
    end else begin
      state_q         <= state_d;
      active_q        <= active_d;
      time_left_q     <= time_left_d;
      used_mask_q     <= used_mask_d;
      commit_valid_q  <= commit_valid_d;
      commit_player_q <= commit_player_d;
      commit_color_q  <= commit_color_d;
      reject_q        <= reject_d;
      timeout_q       <= timeout_d;
      busy_q          <= busy_d;
      game_over_q     <= game_over_d;
      turn_cnt_q      <= turn_cnt_d;
      latched_q       <= latched_d;
    end
  end

  assign active_player = active_q;
  assign busy          = busy_q;
  assign time_left     = time_left_q;
  assign used_mask     = used_mask_q;
  assign commit_valid  = commit_valid_q;
  assign commit_player = commit_player_q;
  assign commit_color  = commit_color_q;
  assign reject        = reject_q;
  assign timeout       = timeout_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: scoreboard bench for turn_scheduler (TICK_DIV=4,
// TURN_TICKS=3, MAX_TURNS=4). The driver keeps a game-level model (claimed
// set, player, commits, TURN_WAIT cycles left before the turn expires) and
// queues the expected commit/reject/timeout events with their cycle; a
// monitor pops and compares whenever the DUT pulses one of them.
module tb_turn_scheduler;

  localparam int TD = 4;
  localparam int TT = 3;
  localparam int MT = 4;
  localparam int B  = TD * TT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  color_id;
  logic        confirm;
  logic        active_player;
  logic        busy;
  logic [5:0]  time_left;
  logic [11:0] used_mask;
  logic        commit_valid;
  logic        commit_player;
  logic [3:0]  commit_color;
  logic        reject;
  logic        timeout;
  logic        game_over;

  turn_scheduler #(
    .TICK_DIV   (TD),
    .TURN_TICKS (TT),
    .MAX_TURNS  (MT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .color_id      (color_id),
    .confirm       (confirm),
    .active_player (active_player),
    .busy          (busy),
    .time_left     (time_left),
    .used_mask     (used_mask),
    .commit_valid  (commit_valid),
    .commit_player (commit_player),
    .commit_color  (commit_color),
    .reject        (reject),
    .timeout       (timeout),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;    // 0 commit, 1 reject, 2 timeout
    int player;
    int color;
    int mask;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // game-level reference model
  int  m_used, m_player, m_turns, m_rem, m_done;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_event(input int k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: kind %0d seen at cycle %0d, none expected", k, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      chk("event_cycle", 32'(cyc), 32'(e.at));
      if (k == 0) begin
        chk("commit_player", 32'(commit_player), 32'(e.player));
        chk("commit_color", 32'(commit_color), 32'(e.color));
        chk("used_mask_at_commit", 32'(used_mask), 32'(e.mask));
      end
    end
  endfunction

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (commit_valid) chk_event(0);
      if (reject)       chk_event(1);
      if (timeout)      chk_event(2);
    end
  end

  function automatic int ticks_of(input int rem);
    return (rem + TD - 1) / TD;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle in a non-TURN_WAIT state with random confirm/start that must be dropped.
  task automatic step_junk();
    confirm  = ($urandom_range(0, 1) == 1);
    start    = ($urandom_range(0, 3) == 0);
    color_id = 4'($urandom_range(0, 15));
    step();
    confirm = 1'b0;
    start   = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_active"}, 32'(active_player), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_time_left"}, 32'(time_left), 32'd0);
    chk({tag, "_used"}, 32'(used_mask), 32'd0);
    chk({tag, "_cvalid"}, 32'(commit_valid), 32'd0);
    chk({tag, "_cplayer"}, 32'(commit_player), 32'd0);
    chk({tag, "_ccolor"}, 32'(commit_color), 32'd12);
    chk({tag, "_reject"}, 32'(reject), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_game_over"}, 32'(game_over), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start    = 1'b0;
    m_used   = 0;
    m_turns  = 0;
    m_player = 0;
    m_rem    = B;
    m_done   = 0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_time_left", 32'(time_left), 32'(TT));
    chk("start_active", 32'(active_player), 32'd0);
    chk("start_used", 32'(used_mask), 32'd0);
    chk("start_game_over", 32'(game_over), 32'd0);
  endtask

  // Wait w TURN_WAIT cycles, then confirm col (or let the turn expire if w >= remaining).
  task automatic move(input int w, input logic [3:0] col);
    ev_t e;
    int  n;
    int  valid;
    if (w >= m_rem) begin
      n = m_rem;
      e = '{2, 0, 0, 0, cyc + n};
      exp_q.push_back(e);
      for (int i = 0; i < n; i++) begin
        chk("time_left_count", 32'(time_left), 32'(ticks_of(m_rem)));
        step();
        m_rem--;
      end
      chk("time_left_zero", 32'(time_left), 32'd0);
      step_junk();
      m_player ^= 1;
      m_rem = B;
    end else begin
      for (int i = 0; i < w; i++) begin
        chk("time_left_count", 32'(time_left), 32'(ticks_of(m_rem)));
        step();
        m_rem--;
      end
      valid = (col < 4'd12) && (((m_used >> col) & 1) == 0);
      if (valid != 0) e = '{0, m_player, int'(col), m_used | (1 << col), cyc + 2};
      else            e = '{1, 0, 0, 0, cyc + 2};
      exp_q.push_back(e);
      confirm  = 1'b1;
      color_id = col;
      step();
      confirm = 1'b0;
      m_rem--;
      if (valid != 0) begin
        m_used |= (1 << col);
        m_turns++;
        step_junk();
        step_junk();
        step_junk();
        m_player ^= 1;
        if (m_turns == MT || m_used == 12'hFFF) m_done = 1;
        else m_rem = B;
      end else begin
        // final tick discarded by the confirm: one more full tick period remains
        if (m_rem == 0) m_rem = TD;
        step_junk();
      end
    end
    chk("active_player", 32'(active_player), 32'(m_player));
    chk("game_over", 32'(game_over), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_done == 0));
    if (m_done == 0) chk("time_left_resume", 32'(time_left), 32'(ticks_of(m_rem)));
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    m_done = 0;
  endtask

  function automatic logic [3:0] pick_color();
    int c;
    if ($urandom_range(0, 9) < 7) begin
      c = $urandom_range(0, 11);
      while (((m_used >> c) & 1) != 0) c = $urandom_range(0, 11);
    end else begin
      c = $urandom_range(0, 15);
    end
    return 4'(c);
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    confirm  = 1'b0;
    color_id = 4'd12;
    m_used = 0; m_player = 0; m_turns = 0; m_rem = B; m_done = 0;
    repeat (2) step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();

    // game 1: directed turns
    do_start();
    move(0, 4'd5);
    chk("mask_after_5", 32'(used_mask), 32'h020);
    move(4, 4'd5);                   // duplicate, after one tick
    move(0, 4'd12);                  // empty pick
    chk("mask_after_rejects", 32'(used_mask), 32'h020);
    chk("time_left_no_reload", 32'(time_left), 32'd2);
    move(100, 4'd0);                 // let player 1 time out
    move(B - 1, 4'd2);               // confirm on the final tick
    move(0, 4'd0);
    move(1, 4'd1);
    chk("game1_mask", 32'(used_mask), 32'h027);

    // game 2: four commits 0..3, ignored confirm in DONE, restart
    do_start();
    for (int c = 0; c < 4; c++) move($urandom_range(0, B - 1), 4'(c));
    chk("game2_over", 32'(game_over), 32'd1);
    chk("game2_busy", 32'(busy), 32'd0);
    chk("game2_mask", 32'(used_mask), 32'h00F);
    confirm  = 1'b1;
    color_id = 4'd4;
    step();
    confirm = 1'b0;
    step();
    chk("done_confirm_mask", 32'(used_mask), 32'h00F);
    chk("done_confirm_over", 32'(game_over), 32'd1);
    do_start();

    // reset while the valid pick sits in CHECK
    confirm  = 1'b1;
    color_id = 4'd7;
    step();
    confirm = 1'b0;
    apply_reset();

    // randomized games
    for (int g = 0; g < 6; g++) begin
      do_start();
      for (int mv = 0; mv < 30 && m_done == 0; mv++) begin
        if ($urandom_range(0, 5) == 0) move(m_rem + $urandom_range(0, 3), 4'd0);
        else move($urandom_range(0, m_rem - 1), pick_color());
      end
      if (m_done == 0) apply_reset();
    end

    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
